tile_rect_plotter: RTL and testbench



---
 rtl/tile_rect_plotter.sv | 159 +++++++++++++++
 tb/tb_tile_rect_plotter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_rect_plotter.sv
// Filled-rectangle rasteriser: queues draw commands and emits one pixel per clock in raster order.
// Optional feature macro PLOT_CLIP_EN suppresses plot for pixels outside SCREEN_W x SCREEN_H.
module tile_rect_plotter #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic [7:0] cmd_w,
  input  logic [6:0] cmd_h,
  input  logic [2:0] cmd_color,
  output logic [7:0] VGA_X,
  output logic [6:0] VGA_Y,
  output logic [2:0] VGA_COLOR,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (SCREEN_W < 1 || SCREEN_W > 256 || SCREEN_H < 1 || SCREEN_H > 128) begin : g_bad_screen
    $error("SCREEN_W/SCREEN_H must fit the 8-bit column and 7-bit row ports");
  end

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] color;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  cmd_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  state_t     r_state;
  logic [7:0] r_x0;
  logic [8:0] r_x_end, r_cur_x;
  logic [7:0] r_y_end, r_cur_y;
  logic [2:0] r_color;
  logic       r_plot, r_done;

  logic       w_full, w_empty, w_push, w_pop, w_empty_cmd;
  logic       w_last_col, w_last, w_vis_start, w_vis_next;
  logic [8:0] w_nx;
  logic [7:0] w_ny;
  cmd_t       w_head;

  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  // cmd_ready looks only at the registered count, so a pop in the same cycle never frees a slot early.
  assign w_push      = cmd_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_empty_cmd = (w_head.w == '0) || (w_head.h == '0);

  always_comb begin
    w_last_col = (r_cur_x == r_x_end);
    w_last     = w_last_col && (r_cur_y == r_y_end);
    w_nx       = w_last_col ? {1'b0, r_x0} : r_cur_x + 9'd1;
    w_ny       = w_last_col ? r_cur_y + 8'd1 : r_cur_y;
`ifdef PLOT_CLIP_EN
    w_vis_start = ({1'b0, w_head.x} < 9'(SCREEN_W)) && ({1'b0, w_head.y} < 8'(SCREEN_H));
    w_vis_next  = (w_nx < 9'(SCREEN_W)) && (w_ny < 8'(SCREEN_H));
`else
    w_vis_start = 1'b1;
    w_vis_next  = 1'b1;
`endif
  end

  // NOTE: the command storage has no reset; only pointers and count are cleared, which is enough to flush.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_mem[r_wr_ptr] <= '{cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // The pixel shown during a DRAW cycle is r_cur_x/r_cur_y; loading it on the pop edge gives 2-cycle latency.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_x0    <= '0;
      r_x_end <= '0;
      r_y_end <= '0;
      r_cur_x <= '0;
      r_cur_y <= '0;
      r_color <= '0;
      r_plot  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_x0    <= w_head.x;
            r_x_end <= {1'b0, w_head.x} + {1'b0, w_head.w} - 9'd1;
            r_y_end <= {1'b0, w_head.y} + {1'b0, w_head.h} - 8'd1;
            r_cur_x <= {1'b0, w_head.x};
            r_cur_y <= {1'b0, w_head.y};
            r_color <= w_head.color;
            if (w_empty_cmd) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_plot  <= 1'b0;
            end else begin
              r_state <= S_DRAW;
              r_plot  <= w_vis_start;
            end
          end
        end
        S_DRAW: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_plot  <= 1'b0;
          end else begin
            r_cur_x <= w_nx;
            r_cur_y <= w_ny;
            r_plot  <= w_vis_next;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = !w_full;
  assign busy      = !w_empty || (r_state != S_IDLE);
  assign done      = r_done;
  assign plot      = r_plot;
  assign VGA_X     = r_cur_x[7:0];
  assign VGA_Y     = r_cur_y[6:0];
  assign VGA_COLOR = r_color;

endmodule

// File: tb/tb_tile_rect_plotter.sv
// Scoreboard bench for tile_rect_plotter: stimulus queues expected pixels, a monitor pops and compares.
module tb_tile_rect_plotter;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;
  logic [7:0] cmd_w;
  logic [6:0] cmd_h;
  logic [2:0] cmd_color;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot, busy, done;

  tile_rect_plotter dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x    (cmd_x),
    .cmd_y    (cmd_y),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .VGA_X    (VGA_X),
    .VGA_Y    (VGA_Y),
    .VGA_COLOR(VGA_COLOR),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   n_plot   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add_rect(input int x, input int y, input int w, input int h, input int c);
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        int px, py;
        bit vis;
        px = x + i;
        py = y + j;
`ifdef PLOT_CLIP_EN
        vis = (px < 160) && (py < 120);
`else
        vis = 1'b1;
`endif
        if (vis) exp_q.push_back('{8'(px), 7'(py), 3'(c)});
      end
    end
  endfunction

  // Monitor: every plotted pixel must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (!RESET) begin
        if (plot) begin
          n_plot++;
          if (exp_q.size() == 0) check("spurious_plot", 32'(plot), 32'd0);
          else check("pixel", 32'({VGA_X, VGA_Y, VGA_COLOR}), 32'(exp_q.pop_front()));
        end
        if (done) begin
          n_done++;
          check("plot_during_done", 32'(plot), 32'd0);
        end
      end
    end
  end

  task automatic push(input int x, input int y, input int w, input int h, input int c, output bit ok);
    @(negedge CLOCK_50);
    cmd_x     = 8'(x);
    cmd_y     = 7'(y);
    cmd_w     = 8'(w);
    cmd_h     = 7'(h);
    cmd_color = 3'(c);
    cmd_valid = 1'b1;
    ok        = cmd_ready;
    @(posedge CLOCK_50);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts falling edges until plot (want_done=0) or done (want_done=1) is seen; -1 on timeout.
  task automatic wait_for(input bit want_done, input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge CLOCK_50);
      if (want_done ? done : plot) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic wait_ndone(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge CLOCK_50);
      #1;
      if (n_done >= target) return;
    end
    check("drain_timeout", 32'(n_done), 32'(target));
  endtask

  initial begin
    bit ok;
    int lat, n0, p0;
    RESET = 1'b1;
    cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    @(negedge CLOCK_50);
    check("rst_vga_x", 32'(VGA_X), 32'd0);
    check("rst_vga_y", 32'(VGA_Y), 32'd0);
    check("rst_color", 32'(VGA_COLOR), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge CLOCK_50);
    #2 RESET = 1'b0;

    // Single 3x2 rectangle with hand-listed pixels.
    exp_q.push_back('{8'd10, 7'd20, 3'd5});
    exp_q.push_back('{8'd11, 7'd20, 3'd5});
    exp_q.push_back('{8'd12, 7'd20, 3'd5});
    exp_q.push_back('{8'd10, 7'd21, 3'd5});
    exp_q.push_back('{8'd11, 7'd21, 3'd5});
    exp_q.push_back('{8'd12, 7'd21, 3'd5});
    p0 = n_plot;
    push(10, 20, 3, 2, 5, ok);
    check("t1_accept", 32'(ok), 32'd1);
    wait_for(1'b0, 10, lat);
    check("t1_first_plot_latency", 32'(lat), 32'd2);
    wait_for(1'b1, 20, lat);
    check("t1_done_after_first_plot", 32'(lat), 32'd6);
    #1;
    check("t1_plot_count", 32'(n_plot - p0), 32'd6);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge CLOCK_50);
    check("t1_done_one_cycle", 32'(done), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);

    // FIFO fill while the engine is stalled on a 40x10 rectangle.
    n0 = n_done;
    add_rect(60, 40, 40, 10, 3);
    push(60, 40, 40, 10, 3, ok);
    check("t2_accept_a", 32'(ok), 32'd1);
    wait_for(1'b0, 10, lat);
    check("t2_a_latency", 32'(lat), 32'd2);
    add_rect(0, 0, 2, 1, 1);
    push(0, 0, 2, 1, 1, ok);
    check("t2_accept_b", 32'(ok), 32'd1);
    add_rect(100, 50, 1, 3, 2);
    push(100, 50, 1, 3, 2, ok);
    check("t2_accept_c", 32'(ok), 32'd1);
    push(5, 5, 0, 0, 4, ok);
    check("t2_accept_d", 32'(ok), 32'd1);
    add_rect(159, 119, 1, 1, 7);
    push(159, 119, 1, 1, 7, ok);
    check("t2_accept_e", 32'(ok), 32'd1);
    @(negedge CLOCK_50);
    check("t2_ready_low_when_full", 32'(cmd_ready), 32'd0);
    cmd_x = 8'd77; cmd_y = 7'd77; cmd_w = 8'd2; cmd_h = 7'd2; cmd_color = 3'd6;
    cmd_valid = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("t2_ready_stays_low", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    wait_ndone(n0 + 5, 2000);
    check("t2_done_count", 32'(n_done - n0), 32'd5);
    check("t2_queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge CLOCK_50);
    check("t2_busy_low", 32'(busy), 32'd0);
    check("t2_ready_high", 32'(cmd_ready), 32'd1);

    // Empty command: no plot, done two cycles after accept.
    p0 = n_plot;
    push(30, 30, 0, 7, 2, ok);
    wait_for(1'b1, 10, lat);
    check("t3_done_latency", 32'(lat), 32'd2);
    @(negedge CLOCK_50);
    check("t3_busy_low", 32'(busy), 32'd0);
    check("t3_no_plot", 32'(n_plot - p0), 32'd0);

    // Corner rectangle crossing the screen edge: 8 DRAW cycles either way.
    add_rect(158, 119, 4, 2, 6);
    push(158, 119, 4, 2, 6, ok);
    wait_for(1'b1, 40, lat);
    check("t4_edge_done_latency", 32'(lat), 32'd10);
    #1;
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Column bound past 255 keeps counting in 9 bits, coordinates truncate.
    add_rect(254, 3, 4, 1, 2);
    push(254, 3, 4, 1, 2, ok);
    wait_for(1'b1, 40, lat);
    check("t4_wrap_done_latency", 32'(lat), 32'd6);
    #1;
    check("t4_wrap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a 20x20 rectangle with two more queued.
    add_rect(20, 20, 20, 20, 1);
    push(20, 20, 20, 20, 1, ok);
    push(0, 0, 5, 5, 3, ok);
    push(50, 50, 5, 5, 4, ok);
    repeat (50) @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    #3 RESET = 1'b1;
    #1;
    check("t5_plot_drops", 32'(plot), 32'd0);
    check("t5_busy_low", 32'(busy), 32'd0);
    check("t5_ready_high", 32'(cmd_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge CLOCK_50);
    #3 RESET = 1'b0;
    n0 = n_done;
    p0 = n_plot;
    repeat (60) @(negedge CLOCK_50);
    #1;
    check("t5_no_pixels_after_reset", 32'(n_plot - p0), 32'd0);
    check("t5_no_done_after_reset", 32'(n_done - n0), 32'd0);
    check("t5_busy_stays_low", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
